// File: rtl/eq_lock_monitor.sv
// Lock/unlock monitor for a 1-bit equality result, with saturating statistics.
// Optional first-mismatch capture ports are enabled by defining EQM_FIRST_MISS_EN.
module eq_lock_monitor #(
    parameter int RUN_LEN  = 4,
    parameter int MISS_LIM = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             eq_valid,
    input  logic             eq_in,
    output logic             locked,
    output logic             lock_pulse,
    output logic             unlock_pulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] match_run,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
`ifdef EQM_FIRST_MISS_EN
    ,
    output logic             first_miss_seen,
    output logic [CNT_W-1:0] first_miss_idx
`endif
);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        LOCKED = 2'b01,
        HOLD   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LEN_C  = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] MISS_LIM_C = CNT_W'(MISS_LIM);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] match_run_n, total_n, mismatch_n;
    logic [CNT_W-1:0] miss_q, miss_n;
    logic             locked_n, lock_pulse_n, unlock_pulse_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    always_comb begin
        state_n        = state_q;
        match_run_n    = match_run;
        miss_n         = miss_q;
        total_n        = total_cnt;
        mismatch_n     = mismatch_cnt;
        lock_pulse_n   = 1'b0;
        unlock_pulse_n = 1'b0;
        if (eq_valid) begin
            total_n = sat_inc(total_cnt);
            if (!eq_in)
                mismatch_n = sat_inc(mismatch_cnt);
            case (state_q)
                SEARCH: begin
                    if (eq_in) begin
                        match_run_n = sat_inc(match_run);
                        if (match_run_n == RUN_LEN_C) begin
                            state_n      = LOCKED;
                            lock_pulse_n = 1'b1;
                        end
                    end else begin
                        match_run_n = '0;
                    end
                end
                LOCKED: begin
                    if (eq_in) begin
                        match_run_n = sat_inc(match_run);
                    end else begin
                        match_run_n = '0;
                        // A single-miss limit skips HOLD and unlocks immediately.
                        if (MISS_LIM == 1) begin
                            state_n        = SEARCH;
                            unlock_pulse_n = 1'b1;
                            miss_n         = '0;
                        end else begin
                            state_n = HOLD;
                            miss_n  = ONE_C;
                        end
                    end
                end
                HOLD: begin
                    if (eq_in) begin
                        state_n     = LOCKED;
                        miss_n      = '0;
                        match_run_n = ONE_C;
                    end else begin
                        miss_n = sat_inc(miss_q);
                        if (miss_n == MISS_LIM_C) begin
                            state_n        = SEARCH;
                            unlock_pulse_n = 1'b1;
                            miss_n         = '0;
                            match_run_n    = '0;
                        end
                    end
                end
                default: begin
                    state_n     = SEARCH;
                    miss_n      = '0;
                    match_run_n = '0;
                end
            endcase
        end
        locked_n = (state_n == LOCKED) || (state_n == HOLD);
    end

    // Clear behaves exactly like reset and swallows a coincident sample.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q      <= SEARCH;
            match_run    <= '0;
            miss_q       <= '0;
            total_cnt    <= '0;
            mismatch_cnt <= '0;
            locked       <= 1'b0;
            lock_pulse   <= 1'b0;
            unlock_pulse <= 1'b0;
        end else begin
            state_q      <= state_n;
            match_run    <= match_run_n;
            miss_q       <= miss_n;
            total_cnt    <= total_n;
            mismatch_cnt <= mismatch_n;
            locked       <= locked_n;
            lock_pulse   <= lock_pulse_n;
            unlock_pulse <= unlock_pulse_n;
        end
    end

    assign state = state_q;

`ifdef EQM_FIRST_MISS_EN
    // Index is the pre-increment sample count, i.e. 0-based position of the miss.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            first_miss_seen <= 1'b0;
            first_miss_idx  <= '0;
        end else if (eq_valid && !eq_in && !first_miss_seen) begin
            first_miss_seen <= 1'b1;
            first_miss_idx  <= total_cnt;
        end
    end
`endif

endmodule
